// File: rtl/cpu_control_fsm_pkg.sv
// Shared types and constants for the multi-cycle CPU control unit:
// state encoding, instruction classes, opcode/ext fields, condition codes
// and flag bit positions.
package cpu_pkg;

  // Control FSM states; the numeric values are visible on state_dbg.
  typedef enum logic [2:0] {
    S_FETCH   = 3'd0,
    S_DECODE  = 3'd1,
    S_EXEC    = 3'd2,
    S_LD_WAIT = 3'd3,
    S_LD_WB   = 3'd4
  } state_t;

  // Instruction classes produced by the decoder.
  typedef enum logic [2:0] {
    CLS_ALU_R = 3'd0,  // register ALU op, result written to rd
    CLS_ALU_I = 3'd1,  // immediate ALU op, result written to rd
    CLS_CMP   = 3'd2,  // register compare, flags only
    CLS_CMPI  = 3'd3,  // immediate compare, flags only
    CLS_LOAD  = 3'd4,  // rd <= mem[rs]
    CLS_STOR  = 3'd5,  // mem[rs] <= rd
    CLS_BCOND = 3'd6,  // conditional PC-relative branch
    CLS_NOP   = 3'd7   // unrecognised encoding, no side effects
  } instr_class_t;

  // Opcode field values (IR[15:12]).
  localparam logic [3:0] OP_RTYPE = 4'b0000;
  localparam logic [3:0] OP_LDST  = 4'b0100;
  localparam logic [3:0] OP_CMPI  = 4'b1011;
  localparam logic [3:0] OP_BCOND = 4'b1100;
  localparam logic [3:0] OP_RSV0  = 4'b1101;
  localparam logic [3:0] OP_RSV1  = 4'b1110;
  localparam logic [3:0] OP_RSV2  = 4'b1111;

  // Extension field values (IR[7:4]).
  localparam logic [3:0] EXT_CMP  = 4'b1011;
  localparam logic [3:0] EXT_LOAD = 4'b0000;
  localparam logic [3:0] EXT_STOR = 4'b0100;

  // Branch condition codes carried in the rd field of a Bcond.
  localparam logic [3:0] COND_EQ      = 4'b0000;
  localparam logic [3:0] COND_NE      = 4'b0001;
  localparam logic [3:0] COND_GT      = 4'b0110;
  localparam logic [3:0] COND_LE      = 4'b0111;
  localparam logic [3:0] COND_ALWAYS_DEFAULT = 4'b1110;

  // Bit positions inside the {C,L,F,Z,N} flag vector.
  localparam int FLAG_N = 0;
  localparam int FLAG_Z = 1;
  localparam int FLAG_F = 2;
  localparam int FLAG_L = 3;
  localparam int FLAG_C = 4;

  // Sign-extend an 8-bit branch displacement to 16 bits.
  function automatic logic [15:0] sext8(input logic [7:0] disp);
    return {{8{disp[7]}}, disp};
  endfunction

endpackage

// File: rtl/cpu_control_fsm_if.sv
// Bundle of memory and datapath control signals between the control unit
// (master) and the datapath/memory side (slave).
//
// Timing contract: every output of the master is a Moore function of the
// control state and IR, stable for the whole cycle; mem_rdata is valid in
// the cycle after the address is presented, and flags reflect the datapath
// flag register as of the current cycle.
interface cpu_control_fsm_if;
  import cpu_pkg::*;

  logic [15:0] mem_rdata;
  logic [4:0]  flags;
  logic [15:0] RegEnable;
  logic [3:0]  MuxControlA;
  logic [3:0]  MuxControlB;
  logic        MuxControlC;
  logic [15:0] AluControl;
  logic        FlagEnable;
  logic        ld_sel;
  logic        mem_addr_sel;
  logic        mem_we;
  logic [15:0] pc;
  logic [2:0]  state_dbg;

  modport master (
    input  mem_rdata, flags,
    output RegEnable, MuxControlA, MuxControlB, MuxControlC, AluControl,
           FlagEnable, ld_sel, mem_addr_sel, mem_we, pc, state_dbg
  );

  modport slave (
    output mem_rdata, flags,
    input  RegEnable, MuxControlA, MuxControlB, MuxControlC, AluControl,
           FlagEnable, ld_sel, mem_addr_sel, mem_we, pc, state_dbg
  );
endinterface

// File: rtl/cpu_control_fsm_decoder.sv
// Combinational instruction decoder: classifies IR, extracts register
// fields and evaluates whether a Bcond is taken against the current flags.
module instr_decoder
  import cpu_pkg::*;
#(
  parameter logic [3:0] COND_ALWAYS = COND_ALWAYS_DEFAULT
) (
  input  logic [15:0]  ir,
  input  logic [4:0]   flags,
  output instr_class_t instrClass,
  output logic [3:0]   rd,
  output logic [3:0]   rs,
  output logic         branchTaken
);

  logic [3:0] op;
  logic [3:0] ext;

  assign op  = ir[15:12];
  assign rd  = ir[11:8];
  assign ext = ir[7:4];
  assign rs  = ir[3:0];

  // Map the opcode/ext pair onto one instruction class.
  always_comb begin
    instrClass = CLS_ALU_I;
    case (op)
      OP_RTYPE: instrClass = (ext == EXT_CMP) ? CLS_CMP : CLS_ALU_R;
      OP_CMPI:  instrClass = CLS_CMPI;
      OP_BCOND: instrClass = CLS_BCOND;
      OP_LDST: begin
        if (ext == EXT_LOAD)      instrClass = CLS_LOAD;
        else if (ext == EXT_STOR) instrClass = CLS_STOR;
        else                      instrClass = CLS_NOP;
      end
      OP_RSV0, OP_RSV1, OP_RSV2: instrClass = CLS_NOP;
      default:  instrClass = CLS_ALU_I;
    endcase
  end

  // Branch condition lives in the rd field; unknown codes fall through.
  always_comb begin
    branchTaken = 1'b0;
    if (rd == COND_ALWAYS) begin
      branchTaken = 1'b1;
    end else begin
      case (rd)
        COND_EQ: branchTaken = flags[FLAG_Z];
        COND_NE: branchTaken = ~flags[FLAG_Z];
        COND_GT: branchTaken = flags[FLAG_N];
        COND_LE: branchTaken = ~flags[FLAG_N];
        default: branchTaken = 1'b0;
      endcase
    end
  end

endmodule

// File: rtl/cpu_control_fsm.sv
// Multi-cycle control unit: FETCH -> DECODE -> EXEC (-> LD_WAIT -> LD_WB).
// Owns IR and PC and drives the datapath control lines as a Moore function
// of the current state and IR.
module cpu_control_fsm
  import cpu_pkg::*;
#(
  parameter logic [15:0] PC_RESET    = 16'h0000,
  parameter logic [3:0]  COND_ALWAYS = 4'b1110
) (
  input logic              clk,
  input logic              reset,
  cpu_control_fsm_if.master bus
);

  state_t       state;
  state_t       stateNext;
  logic [15:0]  ir;
  logic [15:0]  pc;
  instr_class_t instrClass;
  logic [3:0]   rd;
  logic [3:0]   rs;
  logic         branchTaken;

  logic [15:0]  regEnableRaw;
  logic [3:0]   muxA;
  logic [3:0]   muxB;
  logic         muxC;
  logic [15:0]  aluCtl;
  logic         flagEn;
  logic         ldSel;
  logic         addrSel;
  logic         memWeRaw;

  instr_decoder #(.COND_ALWAYS(COND_ALWAYS)) u_decoder (
    .ir          (ir),
    .flags       (bus.flags),
    .instrClass  (instrClass),
    .rd          (rd),
    .rs          (rs),
    .branchTaken (branchTaken)
  );

  // State register; reset always returns to FETCH.
  always_ff @(posedge clk) begin
    if (reset) state <= S_FETCH;
    else       state <= stateNext;
  end

  // Instruction register captures the fetched word at the end of DECODE.
  always_ff @(posedge clk) begin
    if (reset)                  ir <= 16'h0000;
    else if (state == S_DECODE) ir <= bus.mem_rdata;
  end

  // PC increments in DECODE; a taken branch rebases on the branch's own
  // address (pc - 1) plus the sign-extended displacement.
  always_ff @(posedge clk) begin
    if (reset) begin
      pc <= PC_RESET;
    end else if (state == S_DECODE) begin
      pc <= pc + 16'd1;
    end else if (state == S_EXEC && instrClass == CLS_BCOND && branchTaken) begin
      pc <= pc - 16'd1 + sext8(ir[7:0]);
    end
  end

  // Next-state and Moore control outputs decoded from state and IR.
  always_comb begin
    stateNext    = S_FETCH;
    regEnableRaw = 16'h0000;
    muxA         = 4'h0;
    muxB         = 4'h0;
    muxC         = 1'b0;
    aluCtl       = 16'h0000;
    flagEn       = 1'b0;
    ldSel        = 1'b0;
    addrSel      = 1'b0;
    memWeRaw     = 1'b0;
    case (state)
      S_FETCH:  stateNext = S_DECODE;
      S_DECODE: stateNext = S_EXEC;
      S_EXEC: begin
        stateNext = S_FETCH;
        case (instrClass)
          CLS_ALU_R, CLS_ALU_I, CLS_CMP, CLS_CMPI: begin
            muxA   = rd;
            muxB   = rs;
            muxC   = (instrClass == CLS_ALU_I) || (instrClass == CLS_CMPI);
            aluCtl = ir;
            flagEn = 1'b1;
            if (instrClass == CLS_ALU_R || instrClass == CLS_ALU_I)
              regEnableRaw = 16'h0001 << rd;
          end
          CLS_STOR: begin
            muxA     = rs;
            muxB     = rd;
            addrSel  = 1'b1;
            memWeRaw = 1'b1;
          end
          CLS_LOAD: begin
            muxA      = rs;
            addrSel   = 1'b1;
            stateNext = S_LD_WAIT;
          end
          default: ;
        endcase
      end
      S_LD_WAIT: begin
        muxA      = rs;
        addrSel   = 1'b1;
        stateNext = S_LD_WB;
      end
      S_LD_WB: begin
        ldSel        = 1'b1;
        regEnableRaw = 16'h0001 << rd;
      end
      default: stateNext = S_FETCH;
    endcase
  end

  // A reset arriving in any state suppresses the write strobes that cycle,
  // so an interrupted LOAD/STOR never commits.
  assign bus.RegEnable    = reset ? 16'h0000 : regEnableRaw;
  assign bus.mem_we       = reset ? 1'b0 : memWeRaw;
  assign bus.MuxControlA  = muxA;
  assign bus.MuxControlB  = muxB;
  assign bus.MuxControlC  = muxC;
  assign bus.AluControl   = aluCtl;
  assign bus.FlagEnable   = flagEn;
  assign bus.ld_sel       = ldSel;
  assign bus.mem_addr_sel = addrSel;
  assign bus.pc           = pc;
  assign bus.state_dbg    = state;

endmodule

// File: doc/cpu_control_fsm.md
Name: cpu_control_fsm

Overview:
- Multi-cycle control unit that drives the 16-register CPU datapath.
- Fetches 16-bit instructions from synchronous memory, holds them in an instruction register (IR), decodes them, and sequences the datapath control lines: register enables, A/B/immediate mux selects, ALU control word and flag enable.
- Also owns the program counter (PC), the load/ALU select for the main bus, and memory address/write control.

Parameters:
- PC_RESET, 16'h0000, PC value loaded on reset.
- COND_ALWAYS, 4'b1110, Bcond condition code meaning "always taken".

Ports:
- clk  in  1  rising-edge clock
- reset  in  1  synchronous, active-high reset
- mem_rdata  in  16  memory read data, valid the cycle after the address is presented
- flags  in  5  datapath flag register {C,L,F,Z,N} (bit4..bit0)
- RegEnable  out  16  one-hot register write enable; all-zero means no write
- MuxControlA  out  4  register select for ALU bus A
- MuxControlB  out  4  register select for ALU bus B
- MuxControlC  out  1  B-operand select: 1 = immediate, 0 = register
- AluControl  out  16  ALU control word; equals IR during EXEC
- FlagEnable  out  1  flag register capture strobe
- ld_sel  out  1  main-bus source: 1 = mem_rdata, 0 = ALU output
- mem_addr_sel  out  1  memory address source: 0 = pc, 1 = ALU bus A
- mem_we  out  1  memory write strobe; write data is ALU bus B
- pc  out  16  current program counter
- state_dbg  out  3  encoded current state

Behaviour:
- Instruction fields:
  - op = IR[15:12], rd = IR[11:8], ext = IR[7:4], rs = IR[3:0].
- Instruction classes:
  - R-type: op = 0000. Register ALU op; ext selects the operation.
  - CMP: op = 0000, ext = 1011. Also the CMPI immediate form, op = 1011.
  - LOAD: op = 0100, ext = 0000. rd <= mem[rs].
  - STOR: op = 0100, ext = 0100. mem[rs] <= rd.
  - Bcond: op = 1100. rd is the condition; IR[7:0] is a signed 8-bit displacement.
  - I-type: every other op. rd op imm.
- State encoding:
  - FETCH = 0, DECODE = 1, EXEC = 2, LD_WAIT = 3, LD_WB = 4.
- Reset:
  - state = FETCH, pc = PC_RESET, IR = 16'h0000.
  - All control outputs are 0: RegEnable = 0, mux selects = 0, AluControl = 0, FlagEnable = 0, ld_sel = 0, mem_addr_sel = 0, mem_we = 0.
  - A reset that lands in any state, including mid-LOAD or mid-STOR, aborts the instruction; no register write or memory write completes in that cycle.
- Control outputs are Moore: decoded from state and IR only, never from mem_rdata.
- FETCH:
  - mem_addr_sel = 0, so memory sees pc.
  - Next state = DECODE.
- DECODE:
  - IR <= mem_rdata; pc <= pc + 1 (wraps 16'hFFFF -> 0).
  - No enables asserted.
  - Next state = EXEC.
- EXEC, R-type / I-type (non-CMP):
  - MuxControlA = rd; MuxControlB = rs; MuxControlC = 1 for I-type, 0 for R-type.
  - AluControl = IR; ld_sel = 0; RegEnable = 1 << rd; FlagEnable = 1.
  - Next state = FETCH. CPI = 3.
- EXEC, CMP / CMPI:
  - Same selects as the ALU forms, but RegEnable = 0 and FlagEnable = 1.
- EXEC, STOR:
  - MuxControlA = rs (address); MuxControlB = rd (data); MuxControlC = 0.
  - mem_addr_sel = 1; mem_we = 1 for exactly this one cycle.
  - Next state = FETCH.
- EXEC, LOAD:
  - MuxControlA = rs; mem_addr_sel = 1.
  - Next state = LD_WAIT.
- LD_WAIT:
  - mem_addr_sel = 1; MuxControlA = rs (held).
  - Next state = LD_WB.
- LD_WB:
  - ld_sel = 1; RegEnable = 1 << rd; FlagEnable = 0.
  - Next state = FETCH. LOAD CPI = 5.
- EXEC, Bcond:
  - No register writes or flag writes.
  - Taken conditions:
    - cond 0000 EQ: Z = 1
    - cond 0001 NE: Z = 0
    - cond 0110 GT: N = 1
    - cond 0111 LE: N = 0
    - COND_ALWAYS: always taken
    - any other code: not taken
  - If taken: pc <= (pc - 1) + sext(IR[7:0]), i.e. branch address + displacement, modulo 2^16.
  - Next state = FETCH.
- Unrecognised encodings (op = 0100 with any other ext, and op = 1101/1110/1111) execute as NOP: no enables, return to FETCH.
- IR = 16'h0000 after reset is never executed, because FETCH runs first.
- state_dbg values outside 0..4 are unreachable; any illegal state returns to FETCH on the next clock.

Decomposition:
- Shared package cpu_pkg:
  - state encodings;
  - opcode constants OP_RTYPE = 4'b0000, OP_LDST = 4'b0100, OP_BCOND = 4'b1100, OP_CMPI = 4'b1011;
  - ext constants EXT_CMP = 4'b1011, EXT_LOAD = 4'b0000, EXT_STOR = 4'b0100;
  - condition codes and flag bit indices.
- One sub-module, instr_decoder: combinational IR -> class, rd/rs and branch-taken evaluation. The FSM, IR, PC and output registers stay in cpu_control_fsm.

Test Plan:
- Reset asserted mid-LD_WAIT -> next cycle state_dbg = 0, pc = 0, RegEnable = 0, mem_we = 0; no LD_WB write ever occurs.
- mem returns 16'h0352 (ADD r3,r2) at pc 0 -> in EXEC: RegEnable = 16'h0008, MuxControlA = 3, MuxControlB = 2, MuxControlC = 0, FlagEnable = 1, AluControl = 16'h0352; pc = 1; FETCH again 3 cycles after the first FETCH.
- 16'h5307 (ADDI r3,#7) -> MuxControlC = 1, RegEnable = 16'h0008; then 16'hB305 (CMPI) -> FlagEnable = 1, RegEnable = 0.
- 16'h4405 (LOAD r4,[r5]) -> EXEC/LD_WAIT: mem_addr_sel = 1, MuxControlA = 5; LD_WB: ld_sel = 1, RegEnable = 16'h0010; 5 cycles total; mem_we never asserted.
- 16'h4646 (STOR r6,[r6]) -> exactly one cycle with mem_we = 1, mem_addr_sel = 1, MuxControlA = 6, MuxControlB = 6; RegEnable = 0 throughout.
- Bcond:
  - At pc 16'h0010, 16'hC0FC (BEQ −4) with flags Z = 1 -> pc = 16'h000C.
  - Same with Z = 0 -> pc = 16'h0011.
  - 16'hCE7F at pc 16'hFFF0 -> pc = 16'h006F (wrap).
